// File: rtl/uart_dtm_tx_framer_if.sv
// Handshake and line signals between the DTM response mux and the UART TX framer.
// The master supplies payload and length; the slave (framer) reports status and drives the line.
interface uart_dtm_tx_framer_if #(
    parameter int MAX_BYTES = 6
);
    localparam int LW = $clog2(MAX_BYTES + 1);

    logic [8*MAX_BYTES-1:0] DATA_I;
    logic [LW-1:0]          LEN_I;
    logic                   VALID_I;
    logic                   READY_O;
    logic                   TX_O;
    logic                   BUSY_O;
    logic                   DONE_O;

    modport master (
        output DATA_I, LEN_I, VALID_I,
        input  READY_O, TX_O, BUSY_O, DONE_O
    );

    modport slave (
        input  DATA_I, LEN_I, VALID_I,
        output READY_O, TX_O, BUSY_O, DONE_O
    );
endinterface

// File: rtl/uart_dtm_tx_framer.sv
// DTM UART transmit framer: serialises a multi-byte response as 8N1 frames, LSB byte first,
// sending every payload byte equal to ESC twice so the host can separate data from escapes.
module uart_dtm_tx_framer #(
    parameter int         CLK_RATE  = 25000000,
    parameter int         BAUD_RATE = 3000000,
    parameter logic [7:0] ESC       = 8'hB1,
    parameter int         MAX_BYTES = 6
) (
    input logic                 CLK_I,
    input logic                 RST_I,
    uart_dtm_tx_framer_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LW           = $clog2(MAX_BYTES + 1);
    localparam int DW           = 8 * MAX_BYTES;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_BYTES);

    generate
        if (CLKS_PER_BIT < 2) begin : g_baud_check
            $error("uart_dtm_tx_framer: CLK_RATE/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

    state_t          state_q, state_d, phase_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [LW-1:0]   byte_q, byte_d;
    logic            stuff_q, stuff_d;
    logic [DW-1:0]   data_q, data_d;
    logic [LW-1:0]   len_q, len_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            accept_s;
    logic            cnt_end_s;
    logic [LW-1:0]   len_in_s;
    logic [7:0]      cur_byte_s;

    assign accept_s   = bus.VALID_I & ready_q;
    assign cnt_end_s  = (cnt_q == CNT_LAST);
    assign len_in_s   = (bus.LEN_I > LEN_MAX) ? LEN_MAX : bus.LEN_I;
    assign cur_byte_s = 8'(data_q >> {byte_q, 3'b000});

    // NEXT is never registered: it is the decision taken on the last cycle of STOP.
    assign phase_s = (state_q == STOP && cnt_end_s) ? NEXT : state_q;

    // Next-state, counter and output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        stuff_d = stuff_q;
        data_d  = data_q;
        len_d   = len_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        case (phase_s)
            IDLE: begin
                if (accept_s) begin
                    data_d  = bus.DATA_I;
                    len_d   = len_in_s;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    byte_d  = '0;
                    stuff_d = 1'b0;
                    if (len_in_s != '0) begin
                        state_d = START;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_end_s) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_end_s) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                cnt_d = cnt_q + CW'(1);
            end
            NEXT: begin
                cnt_d = '0;
                bit_d = 3'd0;
                // An ESC byte goes out a second time before the byte index moves on.
                if (cur_byte_s == ESC && !stuff_q) begin
                    stuff_d = 1'b1;
                    state_d = START;
                end else begin
                    stuff_d = 1'b0;
                    if (byte_q == len_q - LW'(1)) begin
                        byte_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + LW'(1);
                        state_d = START;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte_s[bit_d];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        // A zero-length accept stays in IDLE but still spends one cycle not ready.
        ready_d = (state_d == IDLE) && !accept_s;
        busy_d  = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= '0;
            stuff_q <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            stuff_q <= stuff_d;
            data_q  <= data_d;
            len_q   <= len_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.TX_O    = tx_q;
    assign bus.READY_O = ready_q;
    assign bus.BUSY_O  = busy_q;
    assign bus.DONE_O  = done_q;
endmodule

// File: tb/tb_uart_dtm_tx_framer.sv
// Directed self-checking bench for uart_dtm_tx_framer at default parameters (8 clocks per bit).
module tb_uart_dtm_tx_framer;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    uart_dtm_tx_framer_if #(.MAX_BYTES(6)) bus ();

    uart_dtm_tx_framer dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks the expected wire bytes cycle by cycle, starting in the first frame cycle,
    // and ends in the completion cycle.
    task automatic check_line(input string tag, input logic [63:0] wb, input int nw);
        for (int f = 0; f < nw; f++) begin
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    logic exp_bit;
                    if (b == 0) exp_bit = 1'b0;
                    else if (b == 9) exp_bit = 1'b1;
                    else exp_bit = wb[8*f + b - 1];
                    chk({tag, "_tx"}, 64'(bus.TX_O), 64'(exp_bit));
                    if (c == 0) begin
                        chk({tag, "_busy"}, 64'(bus.BUSY_O), 64'd1);
                        chk({tag, "_ready"}, 64'(bus.READY_O), 64'd0);
                        chk({tag, "_done_early"}, 64'(bus.DONE_O), 64'd0);
                    end
                    tick();
                end
            end
        end
        chk({tag, "_done"}, 64'(bus.DONE_O), 64'd1);
        chk({tag, "_ready_end"}, 64'(bus.READY_O), 64'd1);
        chk({tag, "_busy_end"}, 64'(bus.BUSY_O), 64'd0);
        chk({tag, "_tx_idle"}, 64'(bus.TX_O), 64'd1);
    endtask

    // Waits (bounded) for READY, then presents one transfer for exactly one cycle.
    task automatic accept(input logic [47:0] d, input logic [2:0] l);
        int n = 0;
        while (bus.READY_O !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk("accept_ready", 64'(bus.READY_O), 64'd1);
        bus.DATA_I  = d;
        bus.LEN_I   = l;
        bus.VALID_I = 1'b1;
        tick();
        bus.VALID_I = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.VALID_I = 1'b0;
        bus.DATA_I  = '0;
        bus.LEN_I   = '0;
        tick();
        tick();
        chk("rst_tx", 64'(bus.TX_O), 64'd1);
        chk("rst_ready", 64'(bus.READY_O), 64'd1);
        chk("rst_busy", 64'(bus.BUSY_O), 64'd0);
        chk("rst_done", 64'(bus.DONE_O), 64'd0);
        rst = 1'b0;
        tick();

        // Single byte 0x5A.
        accept(48'h5A, 3'd1);
        check_line("len1", 64'h5A, 1);
        tick();
        chk("len1_done_pulse", 64'(bus.DONE_O), 64'd0);

        // Four contiguous frames.
        accept(48'h04030201, 3'd4);
        check_line("len4", 64'h04030201, 4);

        // ESC stuffing: B1 12 on the payload becomes B1 B1 12 on the wire.
        accept(48'h12B1, 3'd2);
        check_line("esc1", 64'h12B1B1, 3);
        accept(48'hB1B1, 3'd2);
        check_line("esc2", 64'hB1B1B1B1, 4);

        // Length above MAX_BYTES is clamped to six bytes.
        accept(48'h060504030201, 3'd7);
        check_line("clamp", 64'h060504030201, 6);

        // Zero length: no line activity, DONE next cycle, READY the cycle after.
        tick();
        accept(48'hAA, 3'd0);
        chk("len0_done", 64'(bus.DONE_O), 64'd1);
        chk("len0_ready", 64'(bus.READY_O), 64'd0);
        chk("len0_tx", 64'(bus.TX_O), 64'd1);
        tick();
        chk("len0_ready2", 64'(bus.READY_O), 64'd1);
        chk("len0_done2", 64'(bus.DONE_O), 64'd0);
        chk("len0_tx2", 64'(bus.TX_O), 64'd1);

        // VALID held high and DATA changed during the transfer; next accept at completion.
        bus.DATA_I  = 48'h5A;
        bus.LEN_I   = 3'd1;
        bus.VALID_I = 1'b1;
        tick();
        tick();
        tick();
        tick();
        bus.DATA_I = 48'hFF;
        chk("hold_tx_n4", 64'(bus.TX_O), 64'd0);
        // Re-sync: the first three start-bit cycles were already spent above.
        for (int c = 3; c < 10*CPB; c++) begin
            int b;
            logic e;
            b = c / CPB;
            if (b == 0) e = 1'b0;
            else if (b == 9) e = 1'b1;
            else e = 8'h5A >> (b - 1);
            chk("hold_tx", 64'(bus.TX_O), 64'(e));
            if (c % CPB == 0) chk("hold_ready", 64'(bus.READY_O), 64'd0);
            tick();
        end
        chk("hold_done", 64'(bus.DONE_O), 64'd1);
        chk("hold_ready_end", 64'(bus.READY_O), 64'd1);
        tick();
        bus.VALID_I = 1'b0;
        check_line("second", 64'hFF, 1);

        // Reset in the middle of data bit 3.
        tick();
        accept(48'h5A, 3'd1);
        repeat (39) tick();
        chk("pre_rst_bit3", 64'(bus.TX_O), 64'd1);
        chk("pre_rst_busy", 64'(bus.BUSY_O), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", 64'(bus.TX_O), 64'd1);
        chk("mid_rst_ready", 64'(bus.READY_O), 64'd1);
        chk("mid_rst_busy", 64'(bus.BUSY_O), 64'd0);
        chk("mid_rst_done", 64'(bus.DONE_O), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            chk("abort_no_done", 64'(bus.DONE_O), 64'd0);
            tick();
        end
        accept(48'h5A, 3'd1);
        check_line("after_rst", 64'h5A, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
